// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the two-requester ALU arbiter.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_OR);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Single combinational ALU datapath; illegal opcodes produce zero with the error flag set.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  // Opcode decode; products and differences wrap to DATA_W bits.
  always_comb begin
    result = '0;
    err    = ~is_legal_op(op);
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters with valid/ready handshakes.
// Optional statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cnt0,
  output logic [15:0]       stat_cnt1,
  output logic [15:0]       stat_err
`endif
);

  state_t            state_r;
  state_t            state_nx_s;
  logic              rr_ptr_r;
  logic [2:0]        op_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic              id_r;
  logic [3:0]        cnt_r;

  logic              gnt_s;
  logic              gnt_id_s;
  logic [2:0]        gnt_op_s;
  logic [DATA_W-1:0] gnt_a_s;
  logic [DATA_W-1:0] gnt_b_s;
  logic              exec_last_s;
  logic              rsp_hs_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_err_s;

  // Grant selection: a lone requester wins, a tie goes to the round-robin pointer.
  always_comb begin
    gnt_s    = 1'b0;
    gnt_id_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_s    = 1'b1;
        gnt_id_s = rr_ptr_r;
      end else if (req0_valid) begin
        gnt_s    = 1'b1;
        gnt_id_s = 1'b0;
      end else if (req1_valid) begin
        gnt_s    = 1'b1;
        gnt_id_s = 1'b1;
      end else begin
        gnt_s    = 1'b0;
        gnt_id_s = 1'b0;
      end
    end else begin
      gnt_s    = 1'b0;
      gnt_id_s = 1'b0;
    end
  end

  assign req0_ready  = gnt_s & ~gnt_id_s;
  assign req1_ready  = gnt_s & gnt_id_s;
  assign gnt_op_s    = gnt_id_s ? req1_op : req0_op;
  assign gnt_a_s     = gnt_id_s ? req1_a  : req0_a;
  assign gnt_b_s     = gnt_id_s ? req1_b  : req0_b;
  assign exec_last_s = (state_r == ST_EXEC) && (cnt_r == 4'd0);
  assign rsp_hs_s    = (state_r == ST_RESP) && rsp_valid && rsp_ready;

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_s) state_nx_s = ST_EXEC;
        else       state_nx_s = ST_IDLE;
      end
      ST_EXEC: begin
        if (exec_last_s) state_nx_s = ST_RESP;
        else             state_nx_s = ST_EXEC;
      end
      ST_RESP: begin
        if (rsp_hs_s) state_nx_s = ST_IDLE;
        else          state_nx_s = ST_RESP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Operand capture, round-robin pointer and MUL latency counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= 1'b0;
      op_r     <= 3'b000;
      a_r      <= '0;
      b_r      <= '0;
      id_r     <= 1'b0;
      cnt_r    <= 4'd0;
    end else if (gnt_s) begin
      rr_ptr_r <= ~gnt_id_s;
      op_r     <= gnt_op_s;
      a_r      <= gnt_a_s;
      b_r      <= gnt_b_s;
      id_r     <= gnt_id_s;
      cnt_r    <= (gnt_op_s == OP_MUL) ? 4'(MUL_LAT) : 4'd0;
    end else if ((state_r == ST_EXEC) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  alu_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_r),
    .a      (a_r),
    .b      (b_r),
    .result (alu_res_s),
    .err    (alu_err_s)
  );

  // Response registers stay frozen through RESP until the consumer takes them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_nx_s != ST_IDLE);
      if (exec_last_s) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_r;
        rsp_data  <= alu_res_s;
        rsp_err   <= alu_err_s;
      end else if (rsp_hs_s) begin
        rsp_valid <= 1'b0;
      end else begin
        rsp_valid <= rsp_valid;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cnt0 <= 16'd0;
      stat_cnt1 <= 16'd0;
      stat_err  <= 16'd0;
    end else begin
      if (req0_ready) stat_cnt0 <= sat_inc16(stat_cnt0);
      else            stat_cnt0 <= stat_cnt0;
      if (req1_ready) stat_cnt1 <= sat_inc16(stat_cnt1);
      else            stat_cnt1 <= stat_cnt1;
      if (exec_last_s && alu_err_s) stat_err <= sat_inc16(stat_err);
      else                          stat_err <= stat_err;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter; build with ALU_ARB_STATS_EN to also check counters.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [2:0]    req0_op = 3'd0, req1_op = 3'd0;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          rsp_valid, rsp_id, rsp_err, busy;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]   stat_cnt0, stat_cnt1, stat_err;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .MUL_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1), .stat_err(stat_err)
`endif
  );

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   tests = 0, fails = 0, cyc = 0, last_hs = -10;
  int   m_cnt0 = 0, m_cnt1 = 0, m_err = 0;
  logic m_ptr = 1'b0;
  logic rand_mode = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference ALU written directly from the arithmetic rules.
  function automatic exp_t model(input logic id, input logic [2:0] op,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b, input int due);
    exp_t e;
    e.id = id; e.err = 1'b0; e.due = due;
    case (op)
      3'd0: e.data = a + b;
      3'd1: e.data = a - b;
      3'd2: e.data = a * b;
      3'd3: e.data = a & b;
      3'd4: e.data = a | b;
      default: begin e.data = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Monitor: latency, stability while stalled, and payload on each handshake.
  logic          pv = 1'b0, phs = 1'b0, pid = 1'b0, perr = 1'b0;
  logic [DW-1:0] pd = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (pv && !phs) begin
        check("hold_data", rsp_data, pd);
        check("hold_id", rsp_id, pid);
        check("hold_err", rsp_err, perr);
      end else if (sb.size() == 0) begin
        check("unexpected_rsp", 1'b1, 1'b0);
      end else begin
        check("latency", cyc, sb[0].due);
      end
      if (rsp_ready) begin
        last_hs = cyc;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_id", rsp_id, e.id);
          check("rsp_err", rsp_err, e.err);
        end
      end
    end
    pv = rsp_valid; phs = rsp_valid && rsp_ready;
    pd = rsp_data; pid = rsp_id; perr = rsp_err;
  end

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return DW'($urandom_range(0, 15));
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic new_req(input int who);
    if (who == 0) begin
      req0_valid = 1'b1; req0_op = 3'($urandom_range(0, 7)); req0_a = pick(); req0_b = pick();
    end else begin
      req1_valid = 1'b1; req1_op = 3'($urandom_range(0, 7)); req1_a = pick(); req1_b = pick();
    end
  endtask

  task automatic set_req(input int who, input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (who == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else          begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  // One cycle: predict the grant, check readiness, push expectations, then update stimulus.
  task automatic step();
    logic idle, g, r0, r1, acc0, acc1;
    logic [2:0] op;
    @(negedge clk);
    idle = (sb.size() == 0) && (last_hs != cyc);
    check("busy", busy, !idle);
    g  = (req0_valid && req1_valid) ? m_ptr : (req1_valid && !req0_valid);
    r0 = idle && req0_valid && !g;
    r1 = idle && req1_valid && g;
    check("req0_ready", req0_ready, r0);
    check("req1_ready", req1_ready, r1);
    acc0 = r0; acc1 = r1;
    if (r0 || r1) begin
      op = g ? req1_op : req0_op;
      sb.push_back(model(g, op, g ? req1_a : req0_a, g ? req1_b : req0_b,
                         cyc + 2 + ((op == 3'd2) ? ML : 0)));
      m_ptr = !g;
      gnt_log.push_back(int'(g));
      if (g) m_cnt1++; else m_cnt0++;
      if (op > 3'd4) m_err++;
    end
    @(posedge clk); #1;
    if (acc0) begin
      if (rand_mode && ($urandom_range(0, 1) == 0)) new_req(0); else req0_valid = 1'b0;
    end else if (rand_mode && !req0_valid && ($urandom_range(0, 3) == 0)) new_req(0);
    if (acc1) begin
      if (rand_mode && ($urandom_range(0, 1) == 0)) new_req(1); else req1_valid = 1'b0;
    end else if (rand_mode && !req1_valid && ($urandom_range(0, 3) == 0)) new_req(1);
    if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run(input int limit);
    int n = 0;
    do begin
      step();
      n++;
    end while ((req0_valid || req1_valid || sb.size() != 0) && n < limit);
    if (req0_valid || req1_valid || sb.size() != 0) check("drain_timeout", 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int n);
    req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
`ifdef ALU_ARB_STATS_EN
    check("rst_stat_cnt0", stat_cnt0, 16'd0);
    check("rst_stat_err", stat_err, 16'd0);
`endif
    sb.delete(); m_ptr = 1'b0; last_hs = -10;
    m_cnt0 = 0; m_cnt1 = 0; m_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_stats();
`ifdef ALU_ARB_STATS_EN
    check("stat_cnt0", stat_cnt0, 16'(m_cnt0));
    check("stat_cnt1", stat_cnt1, 16'(m_cnt1));
    check("stat_err", stat_err, 16'(m_err));
`endif
  endtask

  initial begin
    int order[4];
    int n;
    order = '{0, 1, 0, 1};
    do_reset(2);

    // ADD 5+7 from requester 0.
    rsp_ready = 1'b1;
    set_req(0, 3'b000, 32'd5, 32'd7);
    run(20);

    // Contention after reset: expected grant order 0,1,0,1.
    do_reset(1);
    gnt_log.delete();
    repeat (2) begin
      set_req(0, 3'b001, 32'd3, 32'd5);
      set_req(1, 3'b100, 32'h0000_00F0, 32'h0000_000F);
      run(30);
    end
    check("grant_count", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gnt_log.size()) check("grant_order", gnt_log[i], order[i]);

    // MUL with wrapped product, then illegal opcode.
    set_req(1, 3'b010, 32'h0001_0000, 32'h0001_0000);
    run(30);
    do_reset(1);
    set_req(0, 3'b111, 32'd9, 32'd9);
    run(20);
    check_stats();

    // Stall in RESP with both requesters pending.
    set_req(0, 3'b011, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
    n = 0;
    while (req0_valid && n < 10) begin step(); n++; end
    rsp_ready = 1'b0;
    set_req(0, 3'b000, 32'hFFFF_FFFF, 32'd1);
    set_req(1, 3'b001, 32'd0, 32'd1);
    repeat (8) step();
    rsp_ready = 1'b1;
    run(40);

    // Reset in the middle of a MUL: the op must vanish.
    set_req(0, 3'b010, 32'd6, 32'd7);
    n = 0;
    while (req0_valid && n < 10) begin step(); n++; end
    do_reset(1);
    repeat (8) step();
    check("dropped_op_silent", sb.size(), 0);

    // Randomized traffic.
    rand_mode = 1'b1;
    repeat (800) step();
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    run(200);
    check("scoreboard_empty", sb.size(), 0);
    check_stats();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
